lbp_core: RTL and testbench

Local-binary-pattern engine for the 128x128 grayscale frame. It reads pixels from the gray image memory over the `gray_req`/`gray_addr`/`gray_data` port and computes an 8-bit LBP code for every interior pixel. Each code is written to the LBP result memory through `lbp_valid`/`lbp_addr`/`lbp_data`. It sits between the gray memory and `lbp_mem`, and asserts `finish` once the whole frame has been written.

---
 rtl/lbp_pkg.sv | 41 ++++
 rtl/lbp_code_calc.sv | 18 +
 rtl/lbp_core.sv | 177 +++++++++++++++++
 tb/tb_lbp_core.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants for the local-binary-pattern engine: frame geometry defaults,
// FSM state encoding and the map from code bit to 3x3 window position.
package lbp_pkg;

  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;
  localparam int AW_DEF    = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Code bit indices; window cells are numbered row*3 + col
  localparam int NB_TL = 0;
  localparam int NB_T  = 1;
  localparam int NB_TR = 2;
  localparam int NB_L  = 3;
  localparam int NB_R  = 4;
  localparam int NB_BL = 5;
  localparam int NB_B  = 6;
  localparam int NB_BR = 7;

  localparam int WIN_CENTRE = 4;

  function automatic int nb_win_idx(input int bit_idx);
    case (bit_idx)
      NB_TL:   return 0;
      NB_T:    return 1;
      NB_TR:   return 2;
      NB_L:    return 3;
      NB_R:    return 5;
      NB_BL:   return 6;
      NB_B:    return 7;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/lbp_code_calc.sv
// Combinational LBP code: each bit is set when its neighbour is >= the centre
// pixel (unsigned). Window cells are packed as row*3 + col.
module lbp_code_calc
  import lbp_pkg::*;
(
  input  logic [8:0][7:0] i_win,
  output logic [7:0]      o_code
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      localparam int CELL = nb_win_idx(gi);
      assign o_code[gi] = (i_win[CELL] >= i_win[WIN_CENTRE]);
    end
  endgenerate

endmodule

// File: rtl/lbp_core.sv
// LBP engine: scans interior pixels row-major, fetching a full 3x3 window at the
// start of each row and one new column per step, and writes one code per centre.
module lbp_core
  import lbp_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [7:0]    gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  localparam logic [AW-1:0] W_A      = AW'(IMG_W);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 2);
  localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - 2);

  state_t          r_state;
  logic [AW-1:0]   r_row;
  logic [AW-1:0]   r_col;
  logic            r_full;
  logic [3:0]      r_idx;
  logic            r_gray_req;
  logic [AW-1:0]   r_gray_addr;
  logic            r_lbp_valid;
  logic [AW-1:0]   r_lbp_addr;
  logic [7:0]      r_lbp_data;
  logic            r_finish;
  logic [8:0][7:0] r_win;

  logic [8:0][7:0] w_win_next;
  logic [8:0][7:0] w_src;
  logic [8:0]      w_load;
  logic [7:0]      w_code;
  logic [3:0]      w_last_idx;

  // Address of read number idx for the centre (row, col); full fetches walk the
  // window column by column, partial fetches walk column col+1 top to bottom.
  function automatic logic [AW-1:0] fetch_addr(input logic [AW-1:0] row,
                                                input logic [AW-1:0] col,
                                                input logic          full,
                                                input logic [3:0]    idx);
    int unsigned   dr;
    int unsigned   dc;
    logic [AW-1:0] r;
    logic [AW-1:0] c;
    if (full) begin
      dr = 32'(idx) % 3;
      dc = 32'(idx) / 3;
    end else begin
      dr = 32'(idx);
      dc = 2;
    end
    r = row + AW'(dr) - ONE_A;
    c = col + AW'(dc) - ONE_A;
    return AW'(r * W_A) + c;
  endfunction

  assign w_last_idx = r_full ? 4'd8 : 4'd2;

  // Per-cell next value: direct load on full fetches, row-wise shift otherwise
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      localparam int R = gi / 3;
      localparam int C = gi % 3;
      assign w_load[gi] = (r_state == ST_FETCH) &&
                          (r_full ? (r_idx == 4'(C * 3 + R)) : (r_idx == 4'(R)));
      if (C == 2) begin : g_edge
        assign w_src[gi] = gray_data;
      end else begin : g_inner
        assign w_src[gi] = r_full ? gray_data : r_win[gi+1];
      end
      assign w_win_next[gi] = w_load[gi] ? w_src[gi] : r_win[gi];
    end
  endgenerate

  lbp_code_calc u_code (
    .i_win  (w_win_next),
    .o_code (w_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win <= '0;
    end else begin
      r_win <= w_win_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_row       <= ONE_A;
      r_col       <= ONE_A;
      r_full      <= 1'b1;
      r_idx       <= 4'd0;
      r_gray_req  <= 1'b0;
      r_gray_addr <= '0;
      r_lbp_valid <= 1'b0;
      r_lbp_addr  <= '0;
      r_lbp_data  <= '0;
      r_finish    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (gray_ready) begin
            r_state     <= ST_FETCH;
            r_row       <= ONE_A;
            r_col       <= ONE_A;
            r_full      <= 1'b1;
            r_idx       <= 4'd0;
            r_gray_req  <= 1'b1;
            r_gray_addr <= fetch_addr(ONE_A, ONE_A, 1'b1, 4'd0);
          end
        end
        ST_FETCH: begin
          if (r_idx == w_last_idx) begin
            // The code is taken from the window as it will be after this read
            r_state     <= ST_WRITE;
            r_gray_req  <= 1'b0;
            r_gray_addr <= '0;
            r_lbp_valid <= 1'b1;
            r_lbp_addr  <= AW'(r_row * W_A) + r_col;
            r_lbp_data  <= w_code;
          end else begin
            r_idx       <= r_idx + 4'd1;
            r_gray_addr <= fetch_addr(r_row, r_col, r_full, r_idx + 4'd1);
          end
        end
        ST_WRITE: begin
          r_lbp_valid <= 1'b0;
          r_lbp_addr  <= '0;
          r_lbp_data  <= '0;
          r_idx       <= 4'd0;
          if (r_col < LAST_COL) begin
            r_state     <= ST_FETCH;
            r_col       <= r_col + ONE_A;
            r_full      <= 1'b0;
            r_gray_req  <= 1'b1;
            r_gray_addr <= fetch_addr(r_row, r_col + ONE_A, 1'b0, 4'd0);
          end else if (r_row < LAST_ROW) begin
            r_state     <= ST_FETCH;
            r_row       <= r_row + ONE_A;
            r_col       <= ONE_A;
            r_full      <= 1'b1;
            r_gray_req  <= 1'b1;
            r_gray_addr <= fetch_addr(r_row + ONE_A, ONE_A, 1'b1, 4'd0);
          end else begin
            r_state  <= ST_DONE;
            r_finish <= 1'b1;
          end
        end
        default: begin
          r_finish <= 1'b1;
        end
      endcase
    end
  end

  assign gray_req  = r_gray_req;
  assign gray_addr = r_gray_addr;
  assign lbp_valid = r_lbp_valid;
  assign lbp_addr  = r_lbp_addr;
  assign lbp_data  = r_lbp_data;
  assign finish    = r_finish;

endmodule

// File: tb/tb_lbp_core.sv
// Directed bench for lbp_core on a reduced 16x7 frame: ramps, flat, checkerboard,
// fetch order, cycle budget, protocol rules and a mid-frame reset.
module tb_lbp_core;

  localparam int W         = 16;
  localparam int H         = 7;
  localparam int AW        = 7;
  localparam int N         = W * H;
  localparam int ROW_CYC   = 10 + (W - 3) * 4;
  localparam int FRAME_CYC = (H - 2) * ROW_CYC;
  localparam int NWR       = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          gray_ready = 1'b0;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  logic [7:0] gray_mem [N];
  logic [7:0] lbp_mem  [N];

  int n_checks = 0;
  int n_errors = 0;

  bit mon_en = 1'b0;
  int cyc, first_fetch, finish_cyc, wr_n, fetch_n;
  int overlap_cnt, range_cnt, border_cnt, dup_cnt;
  bit prev_valid;
  int fetch_log [12];

  lbp_core #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  assign gray_data = gray_req ? gray_mem[gray_addr] : 8'hzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_border(input int a);
    int r;
    int c;
    r = a / W;
    c = a % W;
    return (a >= N) || (r == 0) || (r >= H - 1) || (c == 0) || (c == W - 1);
  endfunction

  // Hand-derived codes: col ramp D6, row ramp F8, flat FF; on the checkerboard
  // the diagonals share the centre colour, so 0xFF centres give 0xA5.
  function automatic logic [7:0] exp_code(input int pat, input int a);
    int r;
    int c;
    r = a / W;
    c = a % W;
    if (is_border(a)) return 8'h00;
    case (pat)
      0:       return 8'hD6;
      1:       return 8'hF8;
      2:       return 8'hFF;
      default: return ((r + c) % 2 == 1) ? 8'hA5 : 8'hFF;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (gray_req && lbp_valid) overlap_cnt++;
      if (gray_req && int'(gray_addr) >= N) range_cnt++;
      if (lbp_valid && prev_valid) dup_cnt++;
      prev_valid = lbp_valid;
      if (gray_req) begin
        if (first_fetch < 0) first_fetch = cyc;
        if (fetch_n < 12) fetch_log[fetch_n] = int'(gray_addr);
        fetch_n++;
      end
      if (lbp_valid) begin
        wr_n++;
        if (is_border(int'(lbp_addr))) border_cnt++;
        else lbp_mem[lbp_addr] = lbp_data;
      end
      if (finish && finish_cyc < 0) finish_cyc = cyc;
    end
  end

  task automatic start_frame(input int pat, input bit clear);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (pat)
          0:       gray_mem[r*W+c] = 8'(c & 255);
          1:       gray_mem[r*W+c] = 8'(r);
          2:       gray_mem[r*W+c] = 8'h80;
          default: gray_mem[r*W+c] = ((r + c) % 2 == 1) ? 8'hFF : 8'h00;
        endcase
      end
    end
    if (clear) for (int i = 0; i < N; i++) lbp_mem[i] = 8'h00;
    cyc = 0; first_fetch = -1; finish_cyc = -1; wr_n = 0; fetch_n = 0;
    overlap_cnt = 0; range_cnt = 0; border_cnt = 0; dup_cnt = 0; prev_valid = 1'b0;
    mon_en = 1'b1;
    gray_ready = 1'b1;
  endtask

  task automatic finish_frame(input string tag, input int pat, input bit chk_order);
    int code_err;
    int exp_order [12];
    exp_order = '{0, 16, 32, 1, 17, 33, 2, 18, 34, 3, 19, 35};
    for (int i = 0; i < FRAME_CYC + 100 && !finish; i++) @(negedge clk);
    gray_ready = 1'b0;
    check({tag, "_finish_seen"}, 32'(finish), 32'd1);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    check({tag, "_finish_sticky"}, 32'(finish), 32'd1);
    check({tag, "_idle_req"}, 32'(gray_req), 32'd0);
    check({tag, "_idle_valid"}, 32'(lbp_valid), 32'd0);
    check({tag, "_writes"}, wr_n, NWR);
    check({tag, "_finish_cycles"}, finish_cyc - first_fetch, FRAME_CYC);
    check({tag, "_req_valid_overlap"}, overlap_cnt, 0);
    check({tag, "_addr_range"}, range_cnt, 0);
    check({tag, "_border_writes"}, border_cnt, 0);
    check({tag, "_valid_one_cycle"}, dup_cnt, 0);
    if (chk_order)
      for (int i = 0; i < 12; i++)
        check($sformatf("%s_fetch[%0d]", tag, i), fetch_log[i], exp_order[i]);
    code_err = n_errors;
    for (int a = 0; a < N; a++)
      check($sformatf("%s_code[%0d]", tag, a), 32'(lbp_mem[a]), 32'(exp_code(pat, a)));
    code_err = n_errors - code_err;
    $display("frame %s: writes=%0d finish_after=%0d code_errors=%0d",
             tag, wr_n, finish_cyc - first_fetch, code_err);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gray_req"}, 32'(gray_req), 32'd0);
    check({tag, "_gray_addr"}, 32'(gray_addr), 32'd0);
    check({tag, "_lbp_valid"}, 32'(lbp_valid), 32'd0);
    check({tag, "_lbp_addr"}, 32'(lbp_addr), 32'd0);
    check({tag, "_lbp_data"}, 32'(lbp_data), 32'd0);
    check({tag, "_finish"}, 32'(finish), 32'd0);
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_ready_req", 32'(gray_req), 32'd0);

    start_frame(0, 1'b1);
    finish_frame("colramp", 0, 1'b1);

    do_reset();
    start_frame(2, 1'b1);
    finish_frame("flat", 2, 1'b0);

    do_reset();
    start_frame(3, 1'b1);
    finish_frame("checker", 3, 1'b0);

    // Abort a column-ramp frame mid-fetch; the row-ramp rerun must overwrite every code
    do_reset();
    start_frame(0, 1'b1);
    guard = 0;
    while (!(cyc >= 100 && gray_req) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_fetch", 32'(gray_req), 32'd1);
    #1 reset = 1'b0;
    #1 check_outputs_zero("abort");
    gray_ready = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_wait_ready", 32'(gray_req), 32'd0);
    start_frame(1, 1'b0);
    finish_frame("rowramp_after_reset", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
